// File: rtl/muldiv_pkg.sv
// Shared types and opcode classification helpers for the iterative RV-M multiply/divide unit.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_div(input op_e op);
        return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    endfunction

    function automatic logic is_rem(input op_e op);
        return op inside {OP_REM, OP_REMU};
    endfunction

    function automatic logic is_high(input op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_MULHU};
    endfunction

    // MUL keeps only the low half, which is identical for signed and unsigned operands.
    function automatic logic a_signed(input op_e op);
        return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    endfunction

    function automatic logic b_signed(input op_e op);
        return op inside {OP_MULH, OP_DIV, OP_REM};
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add for multiply, restoring shift-subtract for divide.
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            i_div,
    input  logic [XLEN-1:0] i_hi,
    input  logic [XLEN-1:0] i_lo,
    input  logic [XLEN-1:0] i_b,
    output logic [XLEN-1:0] o_hi,
    output logic [XLEN-1:0] o_lo
);

    logic [XLEN:0]   w_addend;
    logic [XLEN:0]   w_sum;
    logic [XLEN:0]   w_shift;
    logic [XLEN-1:0] w_diff;
    logic            w_ge;

    assign w_addend = i_lo[0] ? {1'b0, i_b} : '0;
    assign w_sum    = {1'b0, i_hi} + w_addend;

    // Partial remainder is always below the divisor, so the XLEN-bit difference is exact when w_ge.
    assign w_shift  = {i_hi, i_lo[XLEN-1]};
    assign w_ge     = (w_shift >= {1'b0, i_b});
    assign w_diff   = w_shift[XLEN-1:0] - i_b;

    always_comb begin
        o_hi = w_sum[XLEN:1];
        o_lo = {w_sum[0], i_lo[XLEN-1:1]};
        if (i_div) begin
            o_hi = w_ge ? w_diff : w_shift[XLEN-1:0];
            o_lo = {i_lo[XLEN-2:0], w_ge};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle RV-M multiply/divide unit: 1 bit per cycle on magnitudes, sign fix-up on the final step.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter bit FAST_ZERO = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_valid,
    output logic            o_ready,
    input  logic [2:0]      i_op,
    input  logic [XLEN-1:0] i_operand_a,
    input  logic [XLEN-1:0] i_operand_b,
    input  logic            i_kill,
    output logic            o_valid,
    input  logic            i_ready,
    output logic [XLEN-1:0] o_result
);

    localparam int              CW       = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   CNT_INIT = CW'(XLEN);
    localparam logic [XLEN-1:0] MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

    state_e          r_state;
    op_e             r_op;
    logic [CW-1:0]   r_cnt;
    logic [XLEN-1:0] r_hi;
    logic [XLEN-1:0] r_lo;
    logic [XLEN-1:0] r_b;
    logic            r_neg_q;
    logic            r_neg_r;
    logic [XLEN-1:0] r_result;

    op_e               w_op;
    logic              w_a_neg;
    logic              w_b_neg;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic              w_b_zero;
    logic              w_ovf;
    logic              w_special;
    logic [XLEN-1:0]   w_special_res;
    logic [XLEN-1:0]   w_hi;
    logic [XLEN-1:0]   w_lo;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_final;

    assign w_op     = op_e'(i_op);
    assign w_a_neg  = a_signed(w_op) && i_operand_a[XLEN-1];
    assign w_b_neg  = b_signed(w_op) && i_operand_b[XLEN-1];
    assign w_a_mag  = w_a_neg ? -i_operand_a : i_operand_a;
    assign w_b_mag  = w_b_neg ? -i_operand_b : i_operand_b;
    assign w_b_zero = (i_operand_b == '0);
    assign w_ovf    = is_div(w_op) && b_signed(w_op) && (i_operand_a == MIN_VAL) && (i_operand_b == '1);
    assign w_special = is_div(w_op) && (w_b_zero || w_ovf);
    assign w_special_res = is_rem(w_op) ? (w_b_zero ? i_operand_a : '0)
                                        : (w_b_zero ? '1 : MIN_VAL);

    muldiv_step #(.XLEN(XLEN)) u_step (
        .i_div (is_div(r_op)),
        .i_hi  (r_hi),
        .i_lo  (r_lo),
        .i_b   (r_b),
        .o_hi  (w_hi),
        .o_lo  (w_lo)
    );

    // After the last step, hi/lo hold product halves (MUL) or remainder/quotient (DIV).
    always_comb begin
        w_prod  = r_neg_q ? -{w_hi, w_lo} : {w_hi, w_lo};
        w_final = w_prod[XLEN-1:0];
        if (is_div(r_op)) begin
            if (is_rem(r_op)) w_final = r_neg_r ? -w_hi : w_hi;
            else              w_final = r_neg_q ? -w_lo : w_lo;
        end else if (is_high(r_op)) begin
            w_final = w_prod[2*XLEN-1:XLEN];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_op     <= OP_MUL;
            r_cnt    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_result <= '0;
        end else if (i_kill) begin
            r_state <= IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_valid) begin
                        r_op    <= w_op;
                        r_cnt   <= CNT_INIT;
                        r_hi    <= '0;
                        r_lo    <= w_a_mag;
                        r_b     <= w_b_mag;
                        // A zero divisor yields all-ones unsigned, so the quotient is never negated.
                        r_neg_q <= (w_a_neg ^ w_b_neg) && !(is_div(w_op) && w_b_zero);
                        r_neg_r <= w_a_neg;
                        if (FAST_ZERO && w_special) begin
                            r_result <= w_special_res;
                            r_state  <= DONE;
                        end else begin
                            r_state <= CALC;
                        end
                    end
                end
                CALC: begin
                    r_hi  <= w_hi;
                    r_lo  <= w_lo;
                    r_cnt <= r_cnt - 1'b1;
                    if (r_cnt == CW'(1)) begin
                        r_result <= w_final;
                        r_state  <= DONE;
                    end
                end
                DONE: begin
                    if (i_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_ready  = (r_state == IDLE);
    assign o_valid  = (r_state == DONE);
    assign o_result = r_result;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit (XLEN=32, FAST_ZERO=1) against a plain-arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [2:0]  i_op = 3'd0;
    logic [31:0] i_operand_a = '0;
    logic [31:0] i_operand_b = '0;
    logic        i_kill = 1'b0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [31:0] o_result;

    int          n_checks = 0;
    int          n_pass = 0;
    logic [31:0] exp_res = '0;
    logic        exp_active = 1'b0;

    muldiv_unit #(.XLEN(32), .FAST_ZERO(1'b1)) dut (
        .i_clk       (clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_op        (i_op),
        .i_operand_a (i_operand_a),
        .i_operand_b (i_operand_b),
        .i_kill      (i_kill),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    // Reference: RISC-V M-extension semantics using native 64-bit and 32-bit arithmetic.
    function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        int     ia, ib;
        longint sa, sb, ua, ub, p;
        ia = a;
        ib = b;
        sa = ia;
        sb = ib;
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (op)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return ia / ib;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return ia % ib;
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Every cycle a result is presented it must be expected, correct, and the unit must not be ready.
    always @(negedge clk) begin
        if (i_rst_n && o_valid) begin
            chk("valid_expected", 32'(exp_active), 32'd1);
            chk("result", o_result, exp_res);
            chk("ready_low_in_done", 32'(o_ready), 32'd0);
        end
    end

    task automatic run_op(input string nm, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] lit, input bit use_lit, input int lat, input int hold);
        int          cyc;
        logic [31:0] m;
        m = model(op, a, b);
        if (use_lit) chk({nm, "_model"}, m, lit);
        @(posedge clk); #1;
        chk({nm, "_ready_before"}, 32'(o_ready), 32'd1);
        i_valid     = 1'b1;
        i_op        = op;
        i_operand_a = a;
        i_operand_b = b;
        exp_res     = m;
        exp_active  = 1'b1;
        @(posedge clk); #1;
        i_valid     = 1'b0;
        i_op        = 3'($urandom);
        i_operand_a = $urandom;
        i_operand_b = $urandom;
        cyc = 1;
        forever begin
            @(negedge clk);
            if (o_valid) break;
            cyc++;
            if (cyc > 100) break;
        end
        chk({nm, "_latency"}, 32'(cyc), 32'(lat));
        for (int k = 0; k < hold; k++) begin
            @(posedge clk); #1;
            i_valid     = 1'b1;
            i_op        = 3'($urandom);
            i_operand_a = $urandom;
            i_operand_b = $urandom;
        end
        @(posedge clk); #1;
        i_valid = 1'b0;
        i_ready = 1'b1;
        @(posedge clk); #1;
        i_ready    = 1'b0;
        exp_active = 1'b0;
        chk({nm, "_idle_ready"}, 32'(o_ready), 32'd1);
        chk({nm, "_idle_valid"}, 32'(o_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int saw;
        #12;
        chk("reset_ready", 32'(o_ready), 32'd1);
        chk("reset_valid", 32'(o_valid), 32'd0);
        chk("reset_result", o_result, 32'd0);
        @(posedge clk); #1;
        i_rst_n = 1'b1;

        run_op("mul_7_m3",     3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1, 33, 0);
        run_op("mulh_7_m3",    3'd1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 1, 33, 0);
        run_op("mulhu_max",    3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 33, 10);
        run_op("mulhsu_m1_2",  3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 1, 33, 0);
        run_op("mulh_min_min", 3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1, 33, 0);
        run_op("div_m7_2",     3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1, 33, 0);
        run_op("rem_m7_2",     3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 1, 33, 0);
        run_op("div_7_m2",     3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 1, 33, 0);
        run_op("rem_7_m2",     3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         1, 33, 0);
        run_op("divu_100_7",   3'd5, 32'd100,        32'd7,         32'd14,        1, 33, 0);
        run_op("remu_100_7",   3'd7, 32'd100,        32'd7,         32'd2,         1, 33, 3);
        run_op("div_5_0",      3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1, 1,  0);
        run_op("rem_5_0",      3'd6, 32'd5,          32'd0,         32'd5,         1, 1,  0);
        run_op("divu_x_0",     3'd5, 32'hFFFF_FFFF,  32'd0,         32'hFFFF_FFFF, 1, 1,  0);
        run_op("div_ovf",      3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1, 1,  2);
        run_op("rem_ovf",      3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         1, 1,  0);
        run_op("mulhu_min_2",  3'd3, 32'h8000_0000,  32'd2,         32'd1,         1, 33, 0);

        // Kill in the fifth CALC cycle, then a request presented together with kill.
        @(posedge clk); #1;
        i_valid = 1'b1; i_op = 3'd5; i_operand_a = 32'd1000; i_operand_b = 32'd3;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        i_kill = 1'b1; i_valid = 1'b1;
        @(posedge clk); #1;
        i_kill = 1'b0; i_valid = 1'b0;
        chk("kill_ready", 32'(o_ready), 32'd1);
        chk("kill_valid", 32'(o_valid), 32'd0);
        i_valid = 1'b1; i_kill = 1'b1;
        @(posedge clk); #1;
        i_valid = 1'b0; i_kill = 1'b0;
        chk("kill_blocks_accept", 32'(o_ready), 32'd1);
        saw = 0;
        repeat (40) begin
            @(negedge clk);
            if (o_valid) saw++;
        end
        chk("kill_no_result", 32'(saw), 32'd0);

        // Asynchronous reset in the middle of a multiply.
        @(posedge clk); #1;
        i_valid = 1'b1; i_op = 3'd0; i_operand_a = 32'h1234; i_operand_b = 32'h10;
        @(posedge clk); #1;
        i_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        i_rst_n = 1'b0;
        #2;
        chk("midreset_ready", 32'(o_ready), 32'd1);
        chk("midreset_valid", 32'(o_valid), 32'd0);
        chk("midreset_result", o_result, 32'd0);
        @(posedge clk); #1;
        i_rst_n = 1'b1;
        run_op("after_reset_mul", 3'd0, 32'h1234, 32'h10, 32'h0001_2340, 1, 33, 0);

        for (int i = 0; i < 8; i++) begin
            run_op("rand_op", 3'(i), $urandom, (i == 5) ? 32'($urandom_range(1, 255)) : $urandom,
                   32'd0, 0, 33, i % 3);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
